// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, state encoding and grant helper for the IF/MEM SRAM arbiter.
package mem_bus_arbiter_pkg;

  localparam logic STALL_STOP    = 1'b1;
  localparam logic STALL_NO      = 1'b0;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_MEM  = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  // MEM wins a tie unless it won the previous access, so IF cannot starve.
  function automatic logic pick_mem(input logic if_ok, input logic mem_req, input logic last_mem);
    return mem_req & (~if_ok | ~last_mem);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/ack signals and SRAM-side signals of the arbiter, bundled in one interface.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stallreq;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stallreq, ram_ce, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stallreq, ram_ce, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_wait_cnt.sv
// Loadable down-counter that times one SRAM access; saturates at zero.
module mem_arb_wait_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and load/store,
// holding ram_ce for WAIT_CYCLES clocks per access and acking in the following cycle.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  arb_state_e        r_state;
  logic              r_gnt_mem;
  logic              r_last_mem;
  logic              r_we;
  logic              r_ram_ce;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_ack;
  logic              r_mem_ack;

  logic w_if_ok;
  logic w_gnt_mem;
  logic w_gnt_if;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_stall;

  assign w_if_ok   = bus.if_req & ~bus.flush;
  assign w_gnt_mem = pick_mem(w_if_ok, bus.mem_req, r_last_mem);
  assign w_gnt_if  = w_if_ok & ~w_gnt_mem;
  assign w_load    = (r_state == ARB_IDLE) & (w_gnt_mem | w_gnt_if);
  assign w_dec     = (r_state == ARB_IF) | (r_state == ARB_MEM);

  mem_arb_wait_cnt #(
    .WIDTH (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (WAIT_CYCLES'(WAIT_CYCLES - 1)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_gnt_mem   <= 1'b0;
      r_last_mem  <= 1'b0;
      r_we        <= 1'b0;
      r_ram_ce    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_mem) begin
            r_state   <= ARB_MEM;
            r_gnt_mem <= 1'b1;
            r_addr    <= bus.mem_addr;
            r_we      <= bus.mem_we;
            r_wdata   <= bus.mem_wdata;
            r_ram_ce  <= 1'b1;
          end else if (w_gnt_if) begin
            r_state   <= ARB_IF;
            r_gnt_mem <= 1'b0;
            r_addr    <= bus.if_addr;
            r_we      <= 1'b0;
            r_ram_ce  <= 1'b1;
          end
        end
        ARB_IF: begin
          // A flush discards the fetch outright; nothing is captured or acked.
          if (bus.flush) begin
            r_state  <= ARB_IDLE;
            r_ram_ce <= 1'b0;
          end else if (w_zero) begin
            r_if_rdata <= bus.ram_rdata;
            r_if_ack   <= 1'b1;
            r_ram_ce   <= 1'b0;
            r_state    <= ARB_DONE;
          end
        end
        ARB_MEM: begin
          if (w_zero) begin
            if (!r_we) begin
              r_mem_rdata <= bus.ram_rdata;
            end
            r_mem_ack <= 1'b1;
            r_ram_ce  <= 1'b0;
            r_state   <= ARB_DONE;
          end
        end
        default: begin
          r_last_mem <= r_gnt_mem;
          r_state    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign w_stall = (bus.if_req & ~bus.if_ack & ~bus.flush) | (bus.mem_req & ~bus.mem_ack);

  assign bus.ram_ce    = r_ram_ce ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.ram_we    = (r_ram_ce & r_we) ? WRITE_ENABLE : WRITE_DISABLE;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_ack    = r_if_ack & ~bus.flush;
  assign bus.mem_ack   = r_mem_ack;
  assign bus.stallreq  = (!rst && w_stall) ? STALL_STOP : STALL_NO;

endmodule
